// File: rtl/jtframe_romarb.sv
// SDRAM ROM read arbiter: CH channels, each with a one-entry 32-bit cache, and fixed or round-robin grant.
// Miss to sdram_req takes 1 cen cycle; ok follows data_rdy by 1 cen cycle; holds ack/data until the next cen.
module jtframe_romarb #(
    parameter int CH        = 8,
    parameter int AW        = 18,
    parameter int SW        = 22,
    parameter int RR        = 0,
    parameter int READY_DLY = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             downloading,
    input  logic [CH-1:0]    ch_cs,
    input  logic [CH*AW-1:0] ch_addr,
    input  logic [CH*SW-1:0] ch_offset,
    output logic [CH*16-1:0] ch_dout,
    output logic [CH-1:0]    ch_ok,
    output logic             sdram_req,
    output logic [SW-1:0]    sdram_addr,
    input  logic             sdram_ack,
    input  logic             data_rdy,
    input  logic [31:0]      data_read,
    output logic             ready
);
    localparam int IW = (CH > 1) ? $clog2(CH) : 1;
    localparam int TW = AW - 1;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

    state_t          state, state_nxt;
    logic [CH-1:0]   valid;
    logic [TW-1:0]   tag  [CH];
    logic [31:0]     data [CH];
    logic [CH-1:0]   req;
    logic [IW-1:0]   win, win_nxt, rr_ptr, ptr_nxt;
    logic [TW-1:0]   win_tag, grant_tag;
    logic [AW-1:0]   grant_waddr;
    logic [SW-1:0]   grant_addr;
    logic            found;
    logic            grant, wr_cache, clr_req;
    logic [7:0]      ready_cnt;
    logic            hold;
    int              idx;

    assign hold = !rst_n || downloading;

    always_comb begin
        ch_ok   = '0;
        req     = '0;
        ch_dout = '0;
        for (int i = 0; i < CH; i++) begin
            ch_ok[i]            = ch_cs[i] && valid[i] && (tag[i] == ch_addr[i*AW+1 +: TW]);
            req[i]              = ch_cs[i] && !ch_ok[i];
            ch_dout[i*16 +: 16] = ch_addr[i*AW] ? data[i][31:16] : data[i][15:0];
        end
    end

    // Round robin rotates the search origin; fixed priority always starts at channel 0.
    always_comb begin
        win_nxt = '0;
        found   = 1'b0;
        idx     = 0;
        for (int j = 0; j < CH; j++) begin
            idx = (RR != 0) ? ((int'(rr_ptr) + j) % CH) : j;
            if (!found && req[idx[IW-1:0]]) begin
                found   = 1'b1;
                win_nxt = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        grant_tag   = ch_addr[int'(win_nxt)*AW+1 +: TW];
        grant_waddr = {grant_tag, 1'b0};
        grant_addr  = ch_offset[int'(win_nxt)*SW +: SW] + SW'(grant_waddr);
        ptr_nxt     = (win_nxt == IW'(CH-1)) ? '0 : win_nxt + IW'(1);
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        wr_cache  = 1'b0;
        clr_req   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant     = 1'b1;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    clr_req = 1'b1;
                    // Controller may complete in the same cycle it accepts.
                    if (data_rdy) begin
                        wr_cache  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (data_rdy) begin
                    wr_cache  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (hold) begin
            state      <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            valid      <= '0;
            rr_ptr     <= '0;
            win        <= '0;
            win_tag    <= '0;
            ready      <= 1'b0;
            ready_cnt  <= '0;
        end else if (cen) begin
            state <= state_nxt;
            if (grant) begin
                win        <= win_nxt;
                win_tag    <= grant_tag;
                sdram_addr <= grant_addr;
                sdram_req  <= 1'b1;
                rr_ptr     <= ptr_nxt;
            end
            if (clr_req) begin
                sdram_req <= 1'b0;
            end
            if (wr_cache) begin
                valid[win] <= 1'b1;
            end
            if (!ready) begin
                if (ready_cnt == 8'(READY_DLY - 1)) begin
                    ready <= 1'b1;
                end else begin
                    ready_cnt <= ready_cnt + 8'd1;
                end
            end
        end
    end

    // Cache contents survive a download; only the valid bits are dropped there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                data[i] <= '0;
                tag[i]  <= '0;
            end
        end else if (cen && !downloading && wr_cache) begin
            data[win] <= data_read;
            tag[win]  <= win_tag;
        end
    end
endmodule

// File: tb/tb_jtframe_romarb.sv
module tb_jtframe_romarb;
    localparam int CH = 8;
    localparam int AW = 18;
    localparam int SW = 22;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, cen, downloading;
    logic [CH-1:0]    ch_cs;
    logic [CH*AW-1:0] ch_addr;
    logic [CH*SW-1:0] ch_offset;
    logic [CH*16-1:0] f_dout, r_dout;
    logic [CH-1:0]    f_ok, r_ok;
    logic             f_req, r_req, f_ack, r_ack, f_rdy, r_rdy, f_ready, r_ready;
    logic [SW-1:0]    f_addr, r_addr, a;
    logic [31:0]      f_data, r_data;
    int               errors = 0;
    int               checks = 0;

    jtframe_romarb #(.CH(CH), .AW(AW), .SW(SW), .RR(0), .READY_DLY(15)) u_fix (
        .clk(clk), .rst_n(rst_n), .cen(cen), .downloading(downloading),
        .ch_cs(ch_cs), .ch_addr(ch_addr), .ch_offset(ch_offset),
        .ch_dout(f_dout), .ch_ok(f_ok), .sdram_req(f_req), .sdram_addr(f_addr),
        .sdram_ack(f_ack), .data_rdy(f_rdy), .data_read(f_data), .ready(f_ready)
    );

    jtframe_romarb #(.CH(CH), .AW(AW), .SW(SW), .RR(1), .READY_DLY(15)) u_rr (
        .clk(clk), .rst_n(rst_n), .cen(cen), .downloading(downloading),
        .ch_cs(ch_cs), .ch_addr(ch_addr), .ch_offset(ch_offset),
        .ch_dout(r_dout), .ch_ok(r_ok), .sdram_req(r_req), .sdram_addr(r_addr),
        .sdram_ack(r_ack), .data_rdy(r_rdy), .data_read(r_data), .ready(r_ready)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] v);
        ch_addr[i*AW +: AW] = v;
    endtask

    task automatic set_off(input int i, input logic [SW-1:0] v);
        ch_offset[i*SW +: SW] = v;
    endtask

    task automatic wait_req(input bit rr, output logic [SW-1:0] addr);
        int n = 0;
        while (!(rr ? r_req : f_req) && n < 20) begin
            tick(1);
            n++;
        end
        chk(rr ? "rr_req_seen" : "fix_req_seen", {127'd0, rr ? r_req : f_req}, 128'd1);
        addr = rr ? r_addr : f_addr;
    endtask

    task automatic finish(input bit rr, input logic [31:0] d, input int ack_dly,
                          input int rdy_dly, input bit both);
        tick(ack_dly);
        if (rr) begin
            r_ack = 1'b1;
            if (both) begin r_rdy = 1'b1; r_data = d; end
        end else begin
            f_ack = 1'b1;
            if (both) begin f_rdy = 1'b1; f_data = d; end
        end
        tick(1);
        f_ack = 1'b0; r_ack = 1'b0; f_rdy = 1'b0; r_rdy = 1'b0;
        if (!both) begin
            tick(rdy_dly);
            if (rr) begin r_rdy = 1'b1; r_data = d; end
            else    begin f_rdy = 1'b1; f_data = d; end
            tick(1);
            f_rdy = 1'b0; r_rdy = 1'b0;
        end
    endtask

    initial begin
        int ch;
        rst_n = 1'b0; cen = 1'b1; downloading = 1'b0;
        ch_cs = '0; ch_addr = '0; ch_offset = '0;
        f_ack = 1'b0; r_ack = 1'b0; f_rdy = 1'b0; r_rdy = 1'b0;
        f_data = '0; r_data = '0;
        for (int i = 1; i < CH; i++) set_off(i, 22'(i * 32'h10000));
        tick(3);

        chk("rst_req", {127'd0, f_req}, 128'd0);
        chk("rst_addr", {106'd0, f_addr}, 128'd0);
        chk("rst_ok", {120'd0, f_ok}, 128'd0);
        chk("rst_ready", {127'd0, f_ready}, 128'd0);
        chk("rst_dout", f_dout, 128'd0);
        chk("rr_rst_req", {127'd0, r_req}, 128'd0);

        rst_n = 1'b1;
        tick(14);
        chk("ready_early", {127'd0, f_ready}, 128'd0);
        tick(1);
        chk("ready_on", {127'd0, f_ready}, 128'd1);

        // single miss, odd word selects upper half
        set_addr(0, 18'h5);
        ch_cs = 8'h01;
        wait_req(1'b0, a);
        chk("single_addr", {106'd0, a}, 128'h4);
        finish(1'b0, 32'hBEEF1234, 2, 1, 1'b0);
        chk("single_ok", {120'd0, f_ok}, 128'h01);
        chk("single_dout_hi", {112'd0, f_dout[15:0]}, 128'hBEEF);
        set_addr(0, 18'h4);
        #1;
        chk("single_dout_lo", {112'd0, f_dout[15:0]}, 128'h1234);
        chk("single_ok_lo", {120'd0, f_ok}, 128'h01);
        tick(3);
        chk("single_no_req", {127'd0, f_req}, 128'd0);

        // clock enable low freezes the arbiter
        ch_cs = 8'h00;
        cen = 1'b0;
        set_addr(3, 18'h30);
        ch_cs = 8'h08;
        tick(3);
        chk("cen_hold", {127'd0, f_req}, 128'd0);
        cen = 1'b1;
        wait_req(1'b0, a);
        chk("cen_addr", {106'd0, a}, 128'h030030);
        finish(1'b0, 32'h33334444, 1, 1, 1'b0);
        chk("cen_ok", {120'd0, f_ok}, 128'h08);

        // fixed priority with a late higher-priority miss
        ch_cs = 8'h00;
        set_addr(2, 18'h100); set_addr(5, 18'h100); set_addr(7, 18'h100);
        ch_cs = 8'hA4;
        wait_req(1'b0, a);
        chk("prio_ch2", {106'd0, a}, 128'h020100);
        set_addr(1, 18'h40);
        ch_cs = 8'hA6;
        finish(1'b0, 32'h22222222, 1, 1, 1'b0);
        wait_req(1'b0, a);
        chk("prio_ch1", {106'd0, a}, 128'h010040);
        finish(1'b0, 32'h11111111, 1, 1, 1'b0);
        wait_req(1'b0, a);
        chk("prio_ch5", {106'd0, a}, 128'h050100);
        finish(1'b0, 32'h55555555, 1, 1, 1'b0);
        wait_req(1'b0, a);
        chk("prio_ch7", {106'd0, a}, 128'h070100);
        finish(1'b0, 32'h77777777, 1, 1, 1'b0);
        chk("prio_ok", {120'd0, f_ok}, 128'hA6);

        // offset wraps modulo 2^22
        ch_cs = 8'h00;
        set_off(4, 22'h3FFFFE);
        set_addr(4, 18'h6);
        ch_cs = 8'h10;
        wait_req(1'b0, a);
        chk("wrap_addr", {106'd0, a}, 128'h000004);
        finish(1'b0, 32'h44445555, 1, 1, 1'b0);
        chk("wrap_ok", {120'd0, f_ok}, 128'h10);
        chk("wrap_dout", {112'd0, f_dout[4*16 +: 16]}, 128'h5555);

        // address moves while the fetch is in flight
        ch_cs = 8'h00;
        set_addr(1, 18'h20);
        ch_cs = 8'h02;
        wait_req(1'b0, a);
        chk("flight_addr1", {106'd0, a}, 128'h010020);
        set_addr(1, 18'h22);
        #1;
        chk("flight_pending", {120'd0, f_ok}, 128'h00);
        finish(1'b0, 32'h11110000, 1, 1, 1'b0);
        chk("flight_stale_ok", {120'd0, f_ok}, 128'h00);
        wait_req(1'b0, a);
        chk("flight_addr2", {106'd0, a}, 128'h010022);
        finish(1'b0, 32'h1111ABCD, 1, 1, 1'b0);
        chk("flight_ok", {120'd0, f_ok}, 128'h02);
        chk("flight_dout", {112'd0, f_dout[31:16]}, 128'hABCD);

        // download abort during WAIT_DATA
        ch_cs = 8'h00;
        set_addr(6, 18'h8);
        ch_cs = 8'h40;
        wait_req(1'b0, a);
        tick(1);
        f_ack = 1'b1;
        tick(1);
        f_ack = 1'b0;
        ch_cs = 8'hFF;
        #1;
        chk("dl_before_ok", {120'd0, f_ok}, 128'hBF);
        downloading = 1'b1;
        tick(1);
        chk("dl_req", {127'd0, f_req}, 128'd0);
        chk("dl_addr", {106'd0, f_addr}, 128'd0);
        chk("dl_ok", {120'd0, f_ok}, 128'h00);
        chk("dl_ready", {127'd0, f_ready}, 128'd0);
        tick(3);
        ch_cs = 8'h00;
        downloading = 1'b0;
        f_rdy = 1'b1;
        f_data = 32'hDEADDEAD;
        tick(1);
        f_rdy = 1'b0;
        tick(13);
        chk("dl_ready_early", {127'd0, f_ready}, 128'd0);
        tick(1);
        chk("dl_ready_on", {127'd0, f_ready}, 128'd1);
        ch_cs = 8'hFF;
        #1;
        chk("dl_stale_ok", {120'd0, f_ok}, 128'h00);
        chk("dl_dout_kept", {112'd0, f_dout[15:0]}, 128'h1234);

        // round robin on the second instance
        ch_cs = 8'h00;
        set_addr(0, 18'h100); set_addr(3, 18'h100); set_addr(6, 18'h100);
        ch_cs = 8'h49;
        for (int k = 0; k < 6; k++) begin
            ch = (k % 3) * 3;
            wait_req(1'b1, a);
            chk($sformatf("rr_grant%0d", k), {106'd0, a},
                {106'd0, 22'(ch * 32'h10000 + 32'h100 + 2 * (k / 3))});
            if (k < 5) set_addr(ch, 18'(32'h100 + 2 * (k / 3 + 1)));
            finish(1'b1, 32'h60000000 + 32'(k), 1, 1, k == 5);
        end
        chk("rr_ok", {120'd0, r_ok}, 128'h40);
        chk("rr_dout", {112'd0, r_dout[6*16 +: 16]}, 128'h0005);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
